// File: rtl/aircon_mode_ctrl_if.sv
// Panel bus of the aircon mode controller: raw buttons in, display codes out.
// Pure wiring, no latency of its own.
// No backpressure: outputs are levels plus a one-cycle change strobe.
interface aircon_mode_ctrl_if;
  logic       Power_In;
  logic       Up_In;
  logic       Down_In;
  logic       TurboBtn_In;
  logic [3:0] Thermo_Out;
  logic       Turbo_Out;
  logic       ModeChg_Out;

  // Panel / stimulus side: drives the buttons, watches the display codes.
  modport master (
    output Power_In,
    output Up_In,
    output Down_In,
    output TurboBtn_In,
    input  Thermo_Out,
    input  Turbo_Out,
    input  ModeChg_Out
  );

  // Controller side.
  modport slave (
    input  Power_In,
    input  Up_In,
    input  Down_In,
    input  TurboBtn_In,
    output Thermo_Out,
    output Turbo_Out,
    output ModeChg_Out
  );
endinterface

// File: rtl/aircon_mode_ctrl.sv
// Front-panel mode controller: debounces 4 buttons, runs the fan/cool mode FSM and turbo flag.
// Latency: raw button high from edge N -> outputs update at edge N+DEBOUNCE_CYC+2.
// No backpressure: Thermo_Out/Turbo_Out are levels, ModeChg_Out strobes once per change.
// Optional macro TURBO_TIMEOUT_EN adds a turbo auto-cancel after TURBO_CYC cycles.
module aircon_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TURBO_CYC    = 1000
) (
  input  logic               Clk_In,
  input  logic               Rst_In,
  aircon_mode_ctrl_if.slave  bus
);

  // Debounce counter only needs to reach DEBOUNCE_CYC-1 before the level flips.
  localparam int             DCW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYC - 1);

  // Button bit positions inside the conditioning vectors.
  localparam int B_PWR = 0;
  localparam int B_UP  = 1;
  localparam int B_DN  = 2;
  localparam int B_TB  = 3;

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW_FAN,
    S_HIGH_FAN,
    S_LOW_COOL,
    S_HIGH_COOL
  } state_t;

  if (DEBOUNCE_CYC < 1 || TURBO_CYC < 1) begin : g_param_check
    $error("aircon_mode_ctrl: DEBOUNCE_CYC and TURBO_CYC must both be >= 1");
  end

  logic [3:0]     w_raw;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_db;
  logic [3:0]     r_press;
  logic [DCW-1:0] r_db_cnt [4];

  logic           w_pwr;
  logic           w_up;
  logic           w_dn;
  logic           w_tb;
  logic           w_tmo;

  state_t         r_state;
  state_t         w_nxt_state;
  logic           r_turbo;
  logic           w_nxt_turbo;
  logic [3:0]     r_thermo;
  logic           r_modechg;

  // Display code for each mode: one-hot, or all-zero when off.
  function automatic logic [3:0] f_thermo(input state_t s);
    case (s)
      S_LOW_FAN:   return 4'b0001;
      S_HIGH_FAN:  return 4'b0010;
      S_LOW_COOL:  return 4'b0100;
      S_HIGH_COOL: return 4'b1000;
      default:     return 4'b0000;
    endcase
  endfunction

  assign w_raw = {bus.TurboBtn_In, bus.Down_In, bus.Up_In, bus.Power_In};

  // Synchronise raw buttons, debounce them, and strobe a press on each accepted rising level.
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
            // Only the 0->1 level change counts as a press; release is silent.
            r_press[i]  <= r_sync2[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          // Any sample agreeing with the current level restarts the stability count.
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_pwr = r_press[B_PWR];
  assign w_up  = r_press[B_UP];
  assign w_dn  = r_press[B_DN];
  assign w_tb  = r_press[B_TB];

`ifdef TURBO_TIMEOUT_EN
  localparam int             TCW     = (TURBO_CYC > 1) ? $clog2(TURBO_CYC) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TURBO_CYC - 1);

  logic [TCW-1:0] r_tcnt;

  assign w_tmo = r_turbo && (r_tcnt == TC_LAST);

  // Count cycles spent in turbo; any turbo clear (toggle, OFF, timeout) restarts from zero.
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      r_tcnt <= '0;
    end else if (r_turbo && w_nxt_turbo) begin
      r_tcnt <= r_tcnt + 1'b1;
    end else begin
      r_tcnt <= '0;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Next mode/turbo from accepted presses; power dominates, Up+Down cancel each other.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_turbo = r_turbo;
    if (w_pwr) begin
      // Turbo press alongside power is dropped; leaving or entering OFF both end with turbo off.
      w_nxt_state = (r_state == S_OFF) ? S_LOW_FAN : S_OFF;
      w_nxt_turbo = 1'b0;
    end else if (r_state != S_OFF) begin
      if (w_up && !w_dn) begin
        case (r_state)
          S_LOW_FAN:  w_nxt_state = S_HIGH_FAN;
          S_HIGH_FAN: w_nxt_state = S_LOW_COOL;
          S_LOW_COOL: w_nxt_state = S_HIGH_COOL;
          default:    w_nxt_state = r_state;
        endcase
      end else if (w_dn && !w_up) begin
        case (r_state)
          S_HIGH_COOL: w_nxt_state = S_LOW_COOL;
          S_LOW_COOL:  w_nxt_state = S_HIGH_FAN;
          S_HIGH_FAN:  w_nxt_state = S_LOW_FAN;
          default:     w_nxt_state = r_state;
        endcase
      end
      // A timeout wins over a same-cycle turbo press so the press cannot re-arm turbo.
      if (w_tmo) begin
        w_nxt_turbo = 1'b0;
      end else if (w_tb) begin
        w_nxt_turbo = ~r_turbo;
      end
    end
  end

  // Mode FSM with registered display outputs and a change strobe aligned to the new values.
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      r_state   <= S_OFF;
      r_turbo   <= 1'b0;
      r_thermo  <= 4'b0000;
      r_modechg <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_turbo   <= w_nxt_turbo;
      r_thermo  <= f_thermo(w_nxt_state);
      r_modechg <= (w_nxt_state != r_state) || (w_nxt_turbo != r_turbo);
    end
  end

  assign bus.Thermo_Out  = r_thermo;
  assign bus.Turbo_Out   = r_turbo;
  assign bus.ModeChg_Out = r_modechg;

endmodule

// File: tb/tb_aircon_mode_ctrl.sv
// Bench for aircon_mode_ctrl: randomized button presses against a mode-index reference model.
// Expected changes (value + edge) are queued at stimulus time; a negedge monitor checks them.
// Build with +define+TURBO_TIMEOUT_EN to exercise the turbo auto-cancel.
module tb_aircon_mode_ctrl;

  localparam int DB  = 4;
  localparam int TC  = 20;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  aircon_mode_ctrl_if ifc ();

  aircon_mode_ctrl #(
    .DEBOUNCE_CYC (DB),
    .TURBO_CYC    (TC)
  ) dut (
    .Clk_In (clk),
    .Rst_In (rst),
    .bus    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] thermo;
    logic       turbo;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Values the display should currently hold, as last confirmed by an expected change.
  logic [3:0] cur_thermo = 4'b0000;
  logic       cur_turbo  = 1'b0;

  // Reference model: mode index 0=off, 1..4 = low fan .. high cool.
  int m_mode     = 0;
  bit m_turbo    = 1'b0;
  int m_deadline = 0;

  function automatic logic [3:0] code(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return (m == 0) ? 4'b0000 : (one << (m - 1));
  endfunction

  task automatic push(input int at);
    exp_t x;
    x.thermo = code(m_mode);
    x.turbo  = m_turbo;
    x.at     = at;
    sb.push_back(x);
  endtask

  // Apply one set of presses all accepted at edge a.
  task automatic model_press(input bit p, input bit u, input bit d, input bit t, input int a);
    bit tmo;
    int nm;
    bit nt;
    tmo = 1'b0;
`ifdef TURBO_TIMEOUT_EN
    if (m_turbo && m_deadline < a) begin
      m_turbo = 1'b0;
      push(m_deadline);
    end
    if (m_turbo && m_deadline == a) tmo = 1'b1;
`endif
    nm = m_mode;
    nt = m_turbo;
    if (p) begin
      nm = (m_mode == 0) ? 1 : 0;
      nt = 1'b0;
    end else if (m_mode != 0) begin
      if (u && !d)      nm = (m_mode < 4) ? m_mode + 1 : 4;
      else if (d && !u) nm = (m_mode > 1) ? m_mode - 1 : 1;
      if (tmo)    nt = 1'b0;
      else if (t) nt = !m_turbo;
    end
`ifdef TURBO_TIMEOUT_EN
    if (nt && !m_turbo) m_deadline = a + TC;
`endif
    if (nm != m_mode || nt != m_turbo) begin
      m_mode  = nm;
      m_turbo = nt;
      push(a);
    end
  endtask

`ifdef TURBO_TIMEOUT_EN
  // Queue a pending turbo timeout before any later press could be accepted.
  always @(posedge clk) begin
    #2;
    if (!rst && m_turbo && m_deadline <= cyc + LAT) begin
      m_turbo = 1'b0;
      push(m_deadline);
    end
  end
`endif

  task automatic set_btn(input bit p, input bit u, input bit d, input bit t);
    ifc.Power_In    = p;
    ifc.Up_In       = u;
    ifc.Down_In     = d;
    ifc.TurboBtn_In = t;
  endtask

  task automatic press(input bit p, input bit u, input bit d, input bit t,
                       input int hold, input int gap);
    @(posedge clk);
    #1;
    set_btn(p, u, d, t);
    // First sampled at edge cyc+1; output expected LAT edges later.
    model_press(p, u, d, t, cyc + 1 + LAT);
    repeat (hold) @(posedge clk);
    #1;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (gap) @(posedge clk);
  endtask

  task automatic tap(input bit p, input bit u, input bit d, input bit t);
    press(p, u, d, t, 6, 8);
  endtask

  task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Monitor: each ModeChg_Out pulse must match the oldest expected change; otherwise nothing may move.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (ifc.ModeChg_Out === 1'b1) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: cyc=%0d thermo=%b turbo=%b, no change due",
                   cyc, ifc.Thermo_Out, ifc.Turbo_Out);
        end else begin
          e = sb.pop_front();
          if (ifc.Thermo_Out !== e.thermo || ifc.Turbo_Out !== e.turbo || cyc != e.at) begin
            bad++;
            $display("FAIL change: got thermo=%b turbo=%b at cyc %0d, want thermo=%b turbo=%b at cyc %0d",
                     ifc.Thermo_Out, ifc.Turbo_Out, cyc, e.thermo, e.turbo, e.at);
          end
          cur_thermo = e.thermo;
          cur_turbo  = e.turbo;
        end
      end else if (ifc.ModeChg_Out !== 1'b0 || ifc.Thermo_Out !== cur_thermo ||
                   ifc.Turbo_Out !== cur_turbo) begin
        bad++;
        $display("FAIL steady: cyc=%0d got thermo=%b turbo=%b chg=%b, want thermo=%b turbo=%b chg=0",
                 cyc, ifc.Thermo_Out, ifc.Turbo_Out, ifc.ModeChg_Out, cur_thermo, cur_turbo);
      end
    end
  end

  initial begin
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_thermo", ifc.Thermo_Out, 4'b0000);
    check_val("reset_turbo",  {3'b000, ifc.Turbo_Out}, 4'b0000);
    check_val("reset_chg",    {3'b000, ifc.ModeChg_Out}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a power press discards it.
    @(posedge clk);
    #1;
    ifc.Power_In = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.Power_In = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Power held long: exactly one press.
    press(1'b1, 1'b0, 1'b0, 1'b0, 30, 8);

    // Up x4 then Down x5, with saturation at both ends.
    repeat (4) tap(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tap(1'b0, 1'b0, 1'b1, 1'b0);

    // Bouncing Up never settles long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      ifc.Up_In = 1'b1;
      @(posedge clk);
      #1;
      ifc.Up_In = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (10) @(posedge clk);

    // High cool, turbo on, power off clears turbo, turbo in off ignored.
    repeat (3) tap(1'b0, 1'b1, 1'b0, 1'b0);
    tap(1'b0, 1'b0, 1'b0, 1'b1);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    tap(1'b0, 1'b0, 1'b0, 1'b1);

    // Same-cycle priority cases.
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    tap(1'b1, 1'b1, 1'b0, 1'b0);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    tap(1'b0, 1'b1, 1'b1, 1'b0);
    tap(1'b0, 1'b0, 1'b0, 1'b1);
    tap(1'b1, 1'b0, 1'b0, 1'b1);
    tap(1'b1, 1'b0, 1'b0, 1'b0);

    // Turbo left alone for 100 cycles: times out or stays on, per build.
    tap(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (100) @(posedge clk);

    // Randomized presses, sometimes simultaneous, with occasional long idles.
    for (int i = 0; i < 60; i++) begin
      bit p, u, d, t;
      p = ($urandom % 5) == 0;
      u = ($urandom % 3) == 0;
      d = ($urandom % 3) == 0;
      t = ($urandom % 3) == 0;
      if (!(p || u || d || t)) u = 1'b1;
      press(p, u, d, t, $urandom_range(4, 10), $urandom_range(6, 12));
      if (($urandom % 4) == 0) repeat ($urandom_range(1, 25)) @(posedge clk);
    end

    repeat (40) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_changes: %0d expected changes never appeared, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
